// File: rtl/dsa_job_sched.sv
// dsa_job_sched: job queue in front of the bilinear scaling core.
// It buffers {in_w, in_h, scale_q88} jobs and launches them one after another.
// It holds the core configuration stable while a job runs.
// It also gates JTAG input-BRAM writes, keeps per-job perf counters and sticky errors.
module dsa_job_sched #(
  parameter int DEPTH = 4,
  parameter int TMO_W = 8
) (
  input  logic                     clk_50,
  input  logic                     rst,
  input  logic                     job_push,
  input  logic [15:0]              job_in_w,
  input  logic [15:0]              job_in_h,
  input  logic [15:0]              job_scale_q88,
  input  logic                     abort,
  input  logic                     clr_err,
  output logic                     job_full,
  output logic [$clog2(DEPTH):0]   job_count,
  output logic                     core_start,
  output logic [15:0]              core_in_w,
  output logic [15:0]              core_in_h,
  output logic [15:0]              core_scale_q88,
  input  logic                     core_busy,
  input  logic                     core_done,
  input  logic [31:0]              core_flops,
  output logic                     in_wr_allow,
  output logic                     sched_busy,
  output logic [15:0]              jobs_done,
  output logic [31:0]              last_flops,
  output logic [31:0]              total_flops,
  output logic                     err_badcfg,
  output logic                     err_overflow,
  output logic                     err_timeout
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0]    FULL_CNT = CW'(DEPTH);
  localparam logic [TMO_W-1:0] TMO_MAX  = {TMO_W{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LAUNCH    = 3'd1,
    S_WAIT_BUSY = 3'd2,
    S_RUN       = 3'd3,
    S_RETIRE    = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [47:0]       fifo_q [DEPTH];
  logic [47:0]       fifo_d [DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic [31:0]       flops_cap_q, flops_cap_d;
  logic              core_start_q, core_start_d;
  logic [15:0]       core_in_w_q, core_in_w_d, core_in_h_q, core_in_h_d;
  logic [15:0]       core_scale_q, core_scale_d;
  logic              in_wr_allow_q, in_wr_allow_d;
  logic              sched_busy_q, sched_busy_d;
  logic              job_full_q, job_full_d;
  logic [15:0]       jobs_done_q, jobs_done_d;
  logic [31:0]       last_flops_q, last_flops_d;
  logic [31:0]       total_flops_q, total_flops_d;
  logic              err_badcfg_q, err_badcfg_d;
  logic              err_overflow_q, err_overflow_d;
  logic              err_timeout_q, err_timeout_d;

  logic              cfg_ok_s, can_pop_s, push_acc_s;
  logic              badcfg_ev_s, ovf_ev_s, tmo_ev_s;
  logic [47:0]       head_s;
  logic [32:0]       sum_s;

  // Next-state logic: queue bookkeeping, job sequencing, counters and sticky errors.
  always_comb begin
    cfg_ok_s    = (job_in_w != 16'd0) && (job_in_h != 16'd0) && (job_scale_q88 != 16'd0);
    // A pop only happens where the FSM can hand a job to the core; abort blocks it.
    can_pop_s   = (count_q != {CW{1'b0}}) && !abort &&
                  ((state_q == S_IDLE) || (state_q == S_RETIRE));
    push_acc_s  = job_push && !abort && cfg_ok_s && ((count_q != FULL_CNT) || can_pop_s);
    badcfg_ev_s = job_push && !abort && !cfg_ok_s;
    ovf_ev_s    = job_push && !abort && cfg_ok_s && (count_q == FULL_CNT) && !can_pop_s;
    head_s      = fifo_q[rd_ptr_q];
    sum_s       = {1'b0, total_flops_q} + {1'b0, flops_cap_q};
    tmo_ev_s    = 1'b0;

    fifo_d        = fifo_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    state_d       = state_q;
    tmo_d         = tmo_q;
    flops_cap_d   = flops_cap_q;
    core_in_w_d   = core_in_w_q;
    core_in_h_d   = core_in_h_q;
    core_scale_d  = core_scale_q;
    jobs_done_d   = jobs_done_q;
    last_flops_d  = last_flops_q;
    total_flops_d = total_flops_q;

    if (push_acc_s) begin
      fifo_d[wr_ptr_q] = {job_in_w, job_in_h, job_scale_q88};
      wr_ptr_d         = wr_ptr_q + PW'(1'b1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    // The popped head becomes the core config and stays there until the next pop.
    if (can_pop_s) begin
      core_in_w_d  = head_s[47:32];
      core_in_h_d  = head_s[31:16];
      core_scale_d = head_s[15:0];
      rd_ptr_d     = rd_ptr_q + PW'(1'b1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    if (abort) begin
      rd_ptr_d = wr_ptr_q;
      count_d  = {CW{1'b0}};
    end else begin
      count_d = count_q + CW'(push_acc_s) - CW'(can_pop_s);
    end

    case (state_q)
      S_IDLE: begin
        if (can_pop_s) begin
          state_d = S_LAUNCH;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LAUNCH: begin
        tmo_d   = {TMO_W{1'b0}};
        state_d = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (core_done) begin
          flops_cap_d = core_flops;
          state_d     = S_RETIRE;
        end else if (core_busy) begin
          state_d = S_RUN;
        end else if (tmo_q == TMO_MAX) begin
          // The core never picked the job up, so drop it without touching the counters.
          tmo_ev_s = 1'b1;
          state_d  = S_IDLE;
        end else begin
          tmo_d = tmo_q + TMO_W'(1'b1);
        end
      end
      S_RUN: begin
        if (core_done) begin
          flops_cap_d = core_flops;
          state_d     = S_RETIRE;
        end else begin
          state_d = S_RUN;
        end
      end
      S_RETIRE: begin
        jobs_done_d   = jobs_done_q + 16'd1;
        last_flops_d  = flops_cap_q;
        total_flops_d = sum_s[32] ? 32'hFFFF_FFFF : sum_s[31:0];
        if (can_pop_s) begin
          state_d = S_LAUNCH;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    core_start_d   = (state_d == S_LAUNCH);
    in_wr_allow_d  = (state_d == S_IDLE) && (count_d == {CW{1'b0}});
    sched_busy_d   = (state_d != S_IDLE) || (count_d != {CW{1'b0}});
    job_full_d     = (count_d == FULL_CNT);
    // A same-cycle error event wins over clr_err.
    err_badcfg_d   = (err_badcfg_q   && !clr_err) || badcfg_ev_s;
    err_overflow_d = (err_overflow_q && !clr_err) || ovf_ev_s;
    err_timeout_d  = (err_timeout_q  && !clr_err) || tmo_ev_s;
  end

  // State registers with synchronous reset back to an empty, idle scheduler.
  always_ff @(posedge clk_50) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        fifo_q[i] <= 48'd0;
      end
      state_q        <= S_IDLE;
      wr_ptr_q       <= {PW{1'b0}};
      rd_ptr_q       <= {PW{1'b0}};
      count_q        <= {CW{1'b0}};
      tmo_q          <= {TMO_W{1'b0}};
      flops_cap_q    <= 32'd0;
      core_start_q   <= 1'b0;
      core_in_w_q    <= 16'd0;
      core_in_h_q    <= 16'd0;
      core_scale_q   <= 16'd0;
      in_wr_allow_q  <= 1'b1;
      sched_busy_q   <= 1'b0;
      job_full_q     <= 1'b0;
      jobs_done_q    <= 16'd0;
      last_flops_q   <= 32'd0;
      total_flops_q  <= 32'd0;
      err_badcfg_q   <= 1'b0;
      err_overflow_q <= 1'b0;
      err_timeout_q  <= 1'b0;
    end else begin
      fifo_q         <= fifo_d;
      state_q        <= state_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      tmo_q          <= tmo_d;
      flops_cap_q    <= flops_cap_d;
      core_start_q   <= core_start_d;
      core_in_w_q    <= core_in_w_d;
      core_in_h_q    <= core_in_h_d;
      core_scale_q   <= core_scale_d;
      in_wr_allow_q  <= in_wr_allow_d;
      sched_busy_q   <= sched_busy_d;
      job_full_q     <= job_full_d;
      jobs_done_q    <= jobs_done_d;
      last_flops_q   <= last_flops_d;
      total_flops_q  <= total_flops_d;
      err_badcfg_q   <= err_badcfg_d;
      err_overflow_q <= err_overflow_d;
      err_timeout_q  <= err_timeout_d;
    end
  end

  assign job_full       = job_full_q;
  assign job_count      = count_q;
  assign core_start     = core_start_q;
  assign core_in_w      = core_in_w_q;
  assign core_in_h      = core_in_h_q;
  assign core_scale_q88 = core_scale_q;
  assign in_wr_allow    = in_wr_allow_q;
  assign sched_busy     = sched_busy_q;
  assign jobs_done      = jobs_done_q;
  assign last_flops     = last_flops_q;
  assign total_flops    = total_flops_q;
  assign err_badcfg     = err_badcfg_q;
  assign err_overflow   = err_overflow_q;
  assign err_timeout    = err_timeout_q;

endmodule

// File: tb/tb_dsa_job_sched.sv
// Scoreboard bench for dsa_job_sched.
// Accepted jobs are queued with their expected config.
// A small core model pops and compares them on each core_start, and it keeps the expected counters.
module tb_dsa_job_sched;

  logic        clk_50, rst;
  logic        job_push, abort, clr_err;
  logic [15:0] job_in_w, job_in_h, job_scale_q88;
  logic        job_full;
  logic [2:0]  job_count;
  logic        core_start;
  logic [15:0] core_in_w, core_in_h, core_scale_q88;
  logic        core_busy, core_done;
  logic [31:0] core_flops;
  logic        in_wr_allow, sched_busy;
  logic [15:0] jobs_done;
  logic [31:0] last_flops, total_flops;
  logic        err_badcfg, err_overflow, err_timeout;

  typedef struct {
    logic [15:0] w;
    logic [15:0] h;
    logic [15:0] s;
    logic [31:0] flops;
    bit          hang;
    int          run;
  } job_t;

  job_t        sb[$];
  int          vec_cnt = 0;
  int          mis_cnt = 0;
  int          start_cnt = 0;
  bit          model_active = 0;
  logic [15:0] exp_jobs = 16'd0;
  logic [31:0] exp_last = 32'd0;
  logic [31:0] exp_total = 32'd0;

  dsa_job_sched #(.DEPTH(4), .TMO_W(8)) dut (
    .clk_50(clk_50), .rst(rst), .job_push(job_push), .job_in_w(job_in_w),
    .job_in_h(job_in_h), .job_scale_q88(job_scale_q88), .abort(abort), .clr_err(clr_err),
    .job_full(job_full), .job_count(job_count), .core_start(core_start),
    .core_in_w(core_in_w), .core_in_h(core_in_h), .core_scale_q88(core_scale_q88),
    .core_busy(core_busy), .core_done(core_done), .core_flops(core_flops),
    .in_wr_allow(in_wr_allow), .sched_busy(sched_busy), .jobs_done(jobs_done),
    .last_flops(last_flops), .total_flops(total_flops), .err_badcfg(err_badcfg),
    .err_overflow(err_overflow), .err_timeout(err_timeout)
  );

  initial clk_50 = 1'b0;
  always #10 clk_50 = ~clk_50;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      mis_cnt++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic push_job(input logic [15:0] w, input logic [15:0] h, input logic [15:0] s,
                          input logic [31:0] fl, input bit hang, input int run, input bit acc);
    job_t j;
    @(negedge clk_50);
    job_in_w = w; job_in_h = h; job_scale_q88 = s; job_push = 1'b1;
    if (acc) begin
      j.w = w; j.h = h; j.s = s; j.flops = fl; j.hang = hang; j.run = run;
      sb.push_back(j);
    end
    @(negedge clk_50);
    job_push = 1'b0;
  endtask

  task automatic pulse_clr();
    @(negedge clk_50);
    clr_err = 1'b1;
    @(negedge clk_50);
    clr_err = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while ((sched_busy || model_active) && n < budget) begin
      @(negedge clk_50);
      n++;
    end
    chk(tag, 32'(n < budget), 32'd1);
  endtask

  task automatic wait_busy(input string tag);
    int n = 0;
    while (!core_busy && n < 50) begin
      @(negedge clk_50);
      n++;
    end
    chk(tag, 32'(core_busy), 32'd1);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_full"}, 32'(job_full), 32'd0);
    chk({tag, "_count"}, 32'(job_count), 32'd0);
    chk({tag, "_start"}, 32'(core_start), 32'd0);
    chk({tag, "_wr_allow"}, 32'(in_wr_allow), 32'd1);
    chk({tag, "_sbusy"}, 32'(sched_busy), 32'd0);
    chk({tag, "_jobs"}, 32'(jobs_done), 32'd0);
    chk({tag, "_total"}, total_flops, 32'd0);
    chk({tag, "_errs"}, {29'd0, err_badcfg, err_overflow, err_timeout}, 32'd0);
  endtask

  // Core model: compares the launched config against the scoreboard and answers with busy/done.
  initial begin
    job_t j;
    logic [32:0] tmp;
    core_busy = 1'b0; core_done = 1'b0; core_flops = 32'd0;
    forever begin
      @(negedge clk_50);
      if (core_start) begin
        start_cnt++;
        if (sb.size() == 0) begin
          chk("unexpected_start", 32'(sb.size()), 32'd1);
        end else begin
          j = sb.pop_front();
          chk("cfg_w", {16'd0, core_in_w}, {16'd0, j.w});
          chk("cfg_h", {16'd0, core_in_h}, {16'd0, j.h});
          chk("cfg_scale", {16'd0, core_scale_q88}, {16'd0, j.s});
          if (!j.hang) begin
            model_active = 1'b1;
            @(posedge clk_50); #1 core_busy = 1'b1;
            repeat (j.run) @(posedge clk_50);
            #1 core_done = 1'b1; core_flops = j.flops;
            @(posedge clk_50); #1 core_done = 1'b0; core_busy = 1'b0; core_flops = 32'd0;
            exp_jobs = exp_jobs + 16'd1;
            exp_last = j.flops;
            tmp = {1'b0, exp_total} + {1'b0, j.flops};
            exp_total = tmp[32] ? 32'hFFFF_FFFF : tmp[31:0];
            model_active = 1'b0;
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int starts;
    rst = 1'b1; job_push = 1'b0; abort = 1'b0; clr_err = 1'b0;
    job_in_w = 16'd0; job_in_h = 16'd0; job_scale_q88 = 16'd0;
    repeat (3) @(negedge clk_50);
    rst = 1'b0;
    check_reset("rst");

    // T1: single job, 2-cycle launch latency, counters after retire
    push_job(16'd64, 16'd64, 16'h0200, 32'd1000, 1'b0, 3, 1'b1);
    chk("t1_start_early", 32'(core_start), 32'd0);
    chk("t1_wr_allow_busy", 32'(in_wr_allow), 32'd0);
    @(negedge clk_50);
    chk("t1_start", 32'(core_start), 32'd1);
    wait_idle("t1_idle_timeout", 100);
    chk("t1_jobs", {16'd0, jobs_done}, 32'd1);
    chk("t1_last", last_flops, 32'd1000);
    chk("t1_total", total_flops, 32'd1000);
    chk("t1_wr_allow", 32'(in_wr_allow), 32'd1);

    // T2: fill FIFO while core runs, overflow, then all drain in order
    push_job(16'd100, 16'd50, 16'h0180, 32'd11, 1'b0, 20, 1'b1);
    wait_busy("t2_busy");
    push_job(16'd1, 16'd2, 16'h0001, 32'd21, 1'b0, 2, 1'b1);
    push_job(16'd3, 16'd4, 16'h0002, 32'd22, 1'b0, 2, 1'b1);
    push_job(16'd5, 16'd6, 16'h0003, 32'd23, 1'b0, 2, 1'b1);
    chk("t2_not_full", 32'(job_full), 32'd0);
    push_job(16'd7, 16'd8, 16'h0004, 32'd24, 1'b0, 2, 1'b1);
    chk("t2_full", 32'(job_full), 32'd1);
    chk("t2_ovf_clear", 32'(err_overflow), 32'd0);
    push_job(16'd9, 16'd9, 16'h0005, 32'd25, 1'b0, 2, 1'b0);
    chk("t2_ovf", 32'(err_overflow), 32'd1);
    chk("t2_count", 32'(job_count), 32'd4);
    wait_idle("t2_idle_timeout", 300);
    chk("t2_sb_drained", 32'(sb.size()), 32'd0);
    chk("t2_jobs", {16'd0, jobs_done}, {16'd0, exp_jobs});
    chk("t2_last", last_flops, 32'd24);
    chk("t2_total", total_flops, exp_total);
    pulse_clr();
    chk("t2_ovf_clr", 32'(err_overflow), 32'd0);

    // T3: bad config dropped, sticky error, cleared
    push_job(16'd0, 16'd64, 16'h0100, 32'd0, 1'b0, 2, 1'b0);
    chk("t3_badcfg", 32'(err_badcfg), 32'd1);
    chk("t3_count", 32'(job_count), 32'd0);
    chk("t3_wr_allow", 32'(in_wr_allow), 32'd1);
    pulse_clr();
    chk("t3_badcfg_clr", 32'(err_badcfg), 32'd0);

    // T4: core never goes busy -> timeout, job dropped, next job still runs
    push_job(16'd32, 16'd32, 16'h0100, 32'd777, 1'b1, 0, 1'b1);
    n = 0;
    while (!core_start && n < 20) begin
      @(negedge clk_50);
      n++;
    end
    chk("t4_start_seen", 32'(core_start), 32'd1);
    n = 0;
    push_job(16'd48, 16'd24, 16'h0300, 32'd500, 1'b0, 4, 1'b1);
    n = 2;
    while (!err_timeout && n < 400) begin
      @(negedge clk_50);
      n++;
    end
    chk("t4_tmo_latency", 32'(n), 32'd257);
    chk("t4_jobs_unchanged", {16'd0, jobs_done}, 32'd6);
    wait_idle("t4_idle_timeout", 100);
    chk("t4_jobs", {16'd0, jobs_done}, 32'd7);
    chk("t4_last", last_flops, 32'd500);
    pulse_clr();
    chk("t4_tmo_clr", 32'(err_timeout), 32'd0);

    // T5: full queue behind a running job, abort with a same-cycle push
    push_job(16'd80, 16'd80, 16'h0100, 32'd33, 1'b0, 25, 1'b1);
    wait_busy("t5_busy");
    for (int k = 0; k < 4; k++) begin
      push_job(16'(k + 10), 16'd10, 16'h0100, 32'd1, 1'b0, 2, 1'b0);
    end
    chk("t5_full", 32'(job_full), 32'd1);
    starts = start_cnt;
    @(negedge clk_50);
    abort = 1'b1; job_push = 1'b1;
    job_in_w = 16'd5; job_in_h = 16'd5; job_scale_q88 = 16'h0100;
    @(negedge clk_50);
    abort = 1'b0; job_push = 1'b0;
    chk("t5_count", 32'(job_count), 32'd0);
    chk("t5_full_clr", 32'(job_full), 32'd0);
    chk("t5_no_err", {30'd0, err_overflow, err_badcfg}, 32'd0);
    wait_idle("t5_idle_timeout", 100);
    chk("t5_jobs", {16'd0, jobs_done}, 32'd8);
    repeat (20) @(negedge clk_50);
    chk("t5_no_start", 32'(start_cnt), 32'(starts));

    // T6: total_flops saturation
    push_job(16'd8, 16'd8, 16'h0100, 32'hFFFF_0000, 1'b0, 2, 1'b1);
    push_job(16'd9, 16'd9, 16'h0100, 32'hFFFF_0000, 1'b0, 2, 1'b1);
    wait_idle("t6_idle_timeout", 100);
    chk("t6_total_sat", total_flops, 32'hFFFF_FFFF);
    chk("t6_total_model", total_flops, exp_total);
    chk("t6_last", last_flops, 32'hFFFF_0000);
    chk("t6_jobs", {16'd0, jobs_done}, {16'd0, exp_jobs});

    // Reset in the middle of a launched job: back to reset state, no further start
    push_job(16'd16, 16'd16, 16'h0100, 32'd0, 1'b1, 0, 1'b1);
    repeat (8) @(negedge clk_50);
    rst = 1'b1;
    @(negedge clk_50);
    rst = 1'b0;
    exp_jobs = 16'd0; exp_last = 32'd0; exp_total = 32'd0;
    check_reset("midrst");
    starts = start_cnt;
    repeat (300) @(negedge clk_50);
    chk("midrst_no_tmo", 32'(err_timeout), 32'd0);
    chk("midrst_no_start", 32'(start_cnt), 32'(starts));

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, mis_cnt);
    $finish;
  end

endmodule
